e_mdu: RTL and testbench

Execute-stage multiply/divide unit of the five-stage pipeline. Consumes the two forwarded register-file operands (rs, rt) alongside the ALU and owns the architectural HI/LO registers. Models MIPS multi-cycle latency (5 cycles for mult, 10 for div) through a busy flag that the hazard unit uses to stall HI/LO-dependent instructions in decode. Serves mfhi/mflo results to the E/M pipeline register.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/e_mdu_calc.sv | 59 +++++
 rtl/e_mdu.sv | 107 ++++++++++
 tb/tb_e_mdu.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared opcode/state encodings and default latencies for the execute-stage MDU.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

    // True for the opcodes that start a multi-cycle busy period.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational multiply/divide arithmetic; FSM-free so the top only sequences it.
module e_mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] pend_hi,
    output logic [31:0] pend_lo,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quot;
    logic [31:0] rem;

    // Two's-complement product is exact in 64 bits once both operands are sign-extended.
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

    // Signed divide runs on magnitudes; 0x80000000 stays representable as unsigned.
    assign mag_a    = a[31] ? (32'd0 - a) : a;
    assign mag_b    = b[31] ? (32'd0 - b) : b;
    assign dividend = (op == OP_DIV) ? mag_a : a;
    assign divisor  = (b == 32'd0) ? 32'd1 : ((op == OP_DIV) ? mag_b : b);
    assign quot     = dividend / divisor;
    assign rem      = dividend % divisor;

    // Select the result pair; divide-by-zero keeps HI/LO as they are.
    always_comb begin
        pend_hi     = hi;
        pend_lo     = lo;
        div_by_zero = 1'b0;
        case (op)
            OP_MULT:  {pend_hi, pend_lo} = prod_s;
            OP_MULTU: {pend_hi, pend_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                if (b == 32'd0) begin
                    div_by_zero = 1'b1;
                end else if (op == OP_DIV) begin
                    pend_lo = (a[31] ^ b[31]) ? (32'd0 - quot) : quot;
                    pend_hi = a[31] ? (32'd0 - rem) : rem;
                end else begin
                    pend_lo = quot;
                    pend_hi = rem;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO and models multi-cycle latency via busy.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] mdu_rd
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    state_e             state;
    state_e             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               pend_dbz;
    logic [31:0]        calc_hi;
    logic [31:0]        calc_lo;
    logic               calc_dbz;
    logic               accept;
    logic               is_div;
    logic               idle_start;

    assign idle_start = (state == ST_IDLE) && start;
    assign accept     = idle_start && is_muldiv(mdu_op);
    assign is_div     = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);

    e_mdu_calc u_calc (
        .op          (mdu_op),
        .a           (A),
        .b           (B),
        .hi          (HI),
        .lo          (LO),
        .pend_hi     (calc_hi),
        .pend_lo     (calc_lo),
        .div_by_zero (calc_dbz)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: start a run on a mul/div issue, finish when the count expires.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_BUSY;
            ST_BUSY: if (cnt == CNT_W'(1)) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = 1'b0;
        if (state == ST_BUSY) busy = 1'b1;
    end

    // Counter, pending result and HI/LO; results land one edge before busy drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            pend_hi  <= '0;
            pend_lo  <= '0;
            pend_dbz <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            if (accept) begin
                cnt      <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                pend_hi  <= calc_hi;
                pend_lo  <= calc_lo;
                pend_dbz <= calc_dbz;
            end else if (state == ST_BUSY) begin
                cnt <= cnt - CNT_W'(1);
                if ((cnt == CNT_W'(2)) && !pend_dbz) begin
                    HI <= pend_hi;
                    LO <= pend_lo;
                end
            end
            if (idle_start && (mdu_op == OP_MTHI)) HI <= A;
            if (idle_start && (mdu_op == OP_MTLO)) LO <= A;
        end
    end

    // Move-from read port straight off the architectural registers.
    always_comb begin
        mdu_rd = 32'd0;
        if (mdu_op == OP_MFHI) mdu_rd = HI;
        if (mdu_op == OP_MFLO) mdu_rd = LO;
    end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus queues expected completions, a monitor checks them.
module tb_e_mdu;
    import mdu_pkg::*;

    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] mdu_rd;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    e_mdu dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .mdu_rd (mdu_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural effect of one mul/div on HI/LO.
    task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          inout logic [31:0] hi, inout logic [31:0] lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OP_MULT:  begin p = longint'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            OP_MULTU: begin p = ua * ub;           hi = p[63:32]; lo = p[31:0]; end
            OP_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            OP_DIVU:  if (b != 0) begin lo = a / b; hi = a % b; end
            OP_MTHI:  hi = a;
            OP_MTLO:  lo = a;
            default: ;
        endcase
    endtask

    task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo, input int n);
        exp_t e;
        e.hi = hi; e.lo = lo; e.n = n;
        exp_q.push_back(e);
    endtask

    // Hold start for exactly one rising edge from the current time.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        mdu_op = op;
        A      = a;
        B      = b;
        @(posedge clk);
        #2;
        start  = 1'b0;
        mdu_op = OP_NONE;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: busy still %b after 40 cycles, expected 0", busy);
    endtask

    // Monitor: measure each busy run and check HI/LO in its last cycle and after it.
    int          run = 0;
    logic [31:0] last_hi, last_lo;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            run = 0;
        end else if (busy) begin
            run++;
            last_hi = HI;
            last_lo = LO;
        end else if (run > 0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: completion after %0d busy cycles, expected none", run);
            end else begin
                e = exp_q.pop_front();
                check("sb_busy_len", 32'(run), 32'(e.n));
                check("sb_hi_last", last_hi, e.hi);
                check("sb_lo_last", last_lo, e.lo);
                check("sb_hi", HI, e.hi);
                check("sb_lo", LO, e.lo);
            end
            run = 0;
        end
    end

    initial begin
        logic [3:0]  ops[6];
        logic [3:0]  op;
        logic [31:0] a, b;
        ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV;
        ops[3] = OP_DIVU; ops[4] = OP_MTHI;  ops[5] = OP_MTLO;

        reset = 1'b0; start = 1'b0; mdu_op = OP_NONE; A = '0; B = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_rd", mdu_rd, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #2;

        // Directed cases with hand-computed expectations.
        push_exp(32'hFFFFFFFF, 32'hFFFFFFFA, N_MULT);
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3); wait_idle();
        push_exp(32'hFFFFFFFE, 32'h00000001, N_MULT);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_idle();
        push_exp(32'hFFFFFFFF, 32'hFFFFFFFD, N_DIV);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2); wait_idle();
        push_exp(32'h00000000, 32'h80000000, N_DIV);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF); wait_idle();

        issue(OP_MTHI, 32'd5, 32'd0);
        issue(OP_MTLO, 32'd6, 32'd0);
        push_exp(32'd5, 32'd6, N_DIV);
        issue(OP_DIVU, 32'd100, 32'd0); wait_idle();

        @(posedge clk); #2;
        issue(OP_MTHI, 32'h12345678, 32'd0);
        mdu_op = OP_MFHI; #1;
        check("mfhi_rd", mdu_rd, 32'h12345678);
        mdu_op = OP_MFLO; #1;
        check("mflo_rd", mdu_rd, 32'd6);
        mdu_op = OP_NONE; #1;
        check("none_rd", mdu_rd, 32'd0);

        // A second start while busy must not disturb the first divide.
        @(posedge clk); #2;
        push_exp(32'd2, 32'd14, N_DIV);
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #2 issue(OP_DIV, 32'd9, 32'd3);
        wait_idle();

        // Reset mid-divide discards the result and clears HI/LO at once.
        @(posedge clk); #2;
        push_exp(32'd0, 32'd0, N_DIV);
        issue(OP_DIV, 32'd50, 32'd3);
        @(posedge clk);
        @(posedge clk); #2;
        exp_q.delete();
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #2;
        push_exp(32'hFFFFFFFF, 32'hFFFFFFEB, N_MULT);
        issue(OP_MULT, 32'd7, 32'hFFFFFFFD); wait_idle();

        // Randomized ops against the reference model; mul/div issue back-to-back.
        m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFEB;
        for (int i = 0; i < 30; i++) begin
            op = ops[$urandom_range(5, 0)];
            a  = $urandom;
            b  = ($urandom_range(5, 0) == 0) ? 32'd0 : (($urandom_range(1, 0) == 0) ? $urandom : 32'($urandom_range(20, 1)));
            ref_op(op, a, b, m_hi, m_lo);
            if (is_muldiv(op)) begin
                push_exp(m_hi, m_lo, (op == OP_MULT || op == OP_MULTU) ? N_MULT : N_DIV);
                issue(op, a, b);
                wait_idle();
            end else begin
                issue(op, a, b);
                mdu_op = (op == OP_MTHI) ? OP_MFHI : OP_MFLO; #1;
                check("rand_mt_rd", mdu_rd, (op == OP_MTHI) ? m_hi : m_lo);
                mdu_op = OP_NONE;
                @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
